dmi_target_resp: RTL and testbench
==================================

// Module: dmi_target_resp
// PURPOSE
//  Debug-module-side end of the DMI link: accepts dmi requests from the JTAG DTM, executes them against a key-gated
//  debug register bank, returns one dmi response per request. Sits between dmi_jtag and the debug CSR space.
//  Locked until jtag_key_i is written to KEY_ADDR; MAX_FAILS wrong keys give a sticky lockout.
// PARAMETERS
//  NUM_REGS      8      debug registers, 32 bit each, at BASE_ADDR..BASE_ADDR+NUM_REGS-1
//  BASE_ADDR     7'h04  first register address
//  KEY_ADDR      7'h40  key-unlock address
//  STATUS_ADDR   7'h41  status/relock address
//  MAX_FAILS     3      wrong-key writes before lockout (>=1)
//  ACCESS_CYCLES 1      wait cycles between accept and response (>=1)
// PORTS
//  clk_i            in   1          clock
//  rst_i            in   1          reset, asynchronous, active-high
//  jtag_key_i       in   32         expected unlock key
//  dmi_req_valid_i  in   1          request valid
//  dmi_req_ready_o  out  1          request ready
//  dmi_req_addr_i   in   7          request address
//  dmi_req_op_i     in   2          0 NOP, 1 READ, 2 WRITE, 3 reserved
//  dmi_req_data_i   in   32         write data
//  dmi_resp_valid_o out  1          response valid
//  dmi_resp_ready_i in   1          response ready
//  dmi_resp_data_o  out  32         read data
//  dmi_resp_resp_o  out  2          0 SUCCESS, 2 FAILED
//  unlocked_o       out  1          bank unlocked
//  lockout_o        out  1          sticky lockout
//  regs_o           out  NUM_REGS*32 register bank, reg i at [32i+:32]
// BEHAVIOUR
//  Reset: state IDLE; regs, fail_cnt, unlocked_o, lockout_o, resp_valid/data/resp all 0; dmi_req_ready_o=0 while rst_i high.
//  FSM IDLE->WAIT->RESP->IDLE, one request outstanding.
//  IDLE: dmi_req_ready_o=1; valid&ready captures addr/op/data, cnt<=ACCESS_CYCLES-1, ->WAIT.
//  WAIT: ready=0; cnt!=0: cnt--; cnt==0: execute (state updates on this edge, jtag_key_i sampled now), ->RESP.
//  RESP: resp_valid=1, data/resp stable until dmi_resp_ready_i; on handshake ->IDLE, resp_valid=0.
//  Latency: accept at edge T -> resp_valid from cycle T+ACCESS_CYCLES+1; next accept no earlier than cycle after handshake.
//  Execute rules (data=0 unless stated):
//   NOP: SUCCESS, no change. op 3: FAILED.
//   READ reg: unlocked -> SUCCESS, data=reg; locked -> FAILED.
//   WRITE reg: unlocked -> reg<=data, SUCCESS; locked -> FAILED, no change.
//   WRITE KEY: lockout -> FAILED, no change. data==key -> unlocked<=1, fail_cnt<=0, SUCCESS.
//     Else unlocked<=0, fail_cnt++ (saturating at MAX_FAILS), FAILED; new fail_cnt==MAX_FAILS -> lockout<=1.
//   READ KEY: SUCCESS, data=0 (key never readable).
//   READ STATUS: SUCCESS, data={16'b0, 8'(fail_cnt), 6'b0, lockout, unlocked}, regardless of lock state.
//   WRITE STATUS: data[0]=1 -> unlocked<=0 (relock); SUCCESS. Other bits ignored.
//   Other addresses: FAILED.
//  lockout only cleared by reset; in lockout unlocked stays 0, so all reg accesses FAIL.
//  Reset mid-operation: captured request dropped, no response, no register update.
//  dmi_req_valid_i ignored outside IDLE; dmi_resp_ready_i ignored outside RESP.
// TESTING
//  1 key=32'hCAFE_F00D, WRITE 0x40 data CAFEF00D -> SUCCESS, unlocked_o=1; WRITE 0x05=0x1234 then READ 0x05 -> 0x1234.
//  2 Locked, WRITE 0x04=0xFF -> FAILED, regs_o[31:0]=0; READ 0x04 -> FAILED, data 0.
//  3 Three wrong keys -> each FAILED, lockout_o=1 after 3rd, STATUS read=0x0302; correct key then FAILED, unlocked_o=0.
//  4 Hold dmi_resp_ready_i=0 10 cycles: resp stable, dmi_req_ready_o=0, extra valid ignored; ACCESS_CYCLES=3: resp_valid at T+4.
//  5 Unlocked, WRITE 0x41 data 1 -> unlocked_o=0; READ 0x10 and op 3 -> FAILED; NOP -> SUCCESS.
//  6 rst_i pulsed in WAIT of a WRITE 0x04 -> no response, regs 0, FSM IDLE, unlocked_o=0.

Source files
------------

// File: rtl/dmi_target_resp.sv
// dmi_target_resp: debug-module end of the DMI link.
// Accepts one DMI request at a time from the DTM, executes it against a key-gated bank of 32-bit
// debug registers after ACCESS_CYCLES wait cycles, and holds one response until it is taken.
// The bank starts locked. Writing jtag_key_i to KEY_ADDR unlocks it. MAX_FAILS wrong key writes
// set a sticky lockout that only reset clears.
//
// Ports:
//   clk_i, rst_i        clock; asynchronous active-high reset
//   jtag_key_i          expected unlock key, sampled when a key write executes
//   dmi_req_*           request channel (valid/ready, 7-bit addr, 2-bit op, 32-bit write data)
//   dmi_resp_*          response channel (valid/ready, 32-bit read data, 2-bit status)
//   unlocked_o          bank is unlocked
//   lockout_o           sticky lockout after too many wrong keys
//   regs_o              flattened register bank, register i at [32*i +: 32]
module dmi_target_resp #(
  parameter int unsigned NUM_REGS      = 8,
  parameter logic [6:0]  BASE_ADDR     = 7'h04,
  parameter logic [6:0]  KEY_ADDR      = 7'h40,
  parameter logic [6:0]  STATUS_ADDR   = 7'h41,
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [31:0]           jtag_key_i,
  input  logic                  dmi_req_valid_i,
  output logic                  dmi_req_ready_o,
  input  logic [6:0]            dmi_req_addr_i,
  input  logic [1:0]            dmi_req_op_i,
  input  logic [31:0]           dmi_req_data_i,
  output logic                  dmi_resp_valid_o,
  input  logic                  dmi_resp_ready_i,
  output logic [31:0]           dmi_resp_data_o,
  output logic [1:0]            dmi_resp_resp_o,
  output logic                  unlocked_o,
  output logic                  lockout_o,
  output logic [NUM_REGS*32-1:0] regs_o
);

  localparam int unsigned CntW  = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int unsigned IdxW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned FailW = $clog2(MAX_FAILS + 1);

  localparam logic [1:0] OpNop   = 2'd0;
  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;

  localparam logic [1:0] RespSuccess = 2'd0;
  localparam logic [1:0] RespFailed  = 2'd2;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [6:0]       addr_q;
  logic [1:0]       op_q;
  logic [31:0]      wdata_q;
  logic [31:0]      regs_q [NUM_REGS];
  logic [FailW-1:0] fail_q;
  logic             unlocked_q;
  logic             lockout_q;
  logic             resp_valid_q;
  logic [31:0]      resp_data_q;
  logic [1:0]       resp_resp_q;

  // Execute decode for the captured request; only applied on the last WAIT edge.
  logic [7:0]       reg_off;
  logic             reg_hit;
  logic [IdxW-1:0]  reg_idx;
  logic [1:0]       ex_resp;
  logic [31:0]      ex_data;
  logic             ex_reg_we;
  logic             ex_unlocked;
  logic             ex_lockout;
  logic [FailW-1:0] ex_fail;

  assign reg_off = {1'b0, addr_q} - {1'b0, BASE_ADDR};
  assign reg_hit = (addr_q >= BASE_ADDR) && (reg_off < 8'(NUM_REGS));
  assign reg_idx = reg_off[IdxW-1:0];

  always_comb begin
    ex_resp     = RespFailed;
    ex_data     = '0;
    ex_reg_we   = 1'b0;
    ex_unlocked = unlocked_q;
    ex_lockout  = lockout_q;
    ex_fail     = fail_q;
    if (op_q == OpNop) begin
      ex_resp = RespSuccess;
    end else if (op_q == OpRead || op_q == OpWrite) begin
      if (reg_hit) begin
        if (unlocked_q) begin
          ex_resp = RespSuccess;
          if (op_q == OpRead) ex_data = regs_q[reg_idx];
          else                ex_reg_we = 1'b1;
        end
      end else if (addr_q == KEY_ADDR) begin
        if (op_q == OpRead) begin
          // Key is write-only; reads always succeed with zero data.
          ex_resp = RespSuccess;
        end else if (!lockout_q) begin
          if (wdata_q == jtag_key_i) begin
            ex_resp     = RespSuccess;
            ex_unlocked = 1'b1;
            ex_fail     = '0;
          end else begin
            ex_unlocked = 1'b0;
            if (fail_q != FailW'(MAX_FAILS)) ex_fail = fail_q + 1'b1;
            if (ex_fail == FailW'(MAX_FAILS)) ex_lockout = 1'b1;
          end
        end
      end else if (addr_q == STATUS_ADDR) begin
        ex_resp = RespSuccess;
        if (op_q == OpRead) begin
          ex_data = {16'b0, 8'(fail_q), 6'b0, lockout_q, unlocked_q};
        end else if (wdata_q[0]) begin
          ex_unlocked = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      op_q         <= '0;
      wdata_q      <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      fail_q       <= '0;
      unlocked_q   <= 1'b0;
      lockout_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_resp_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (dmi_req_valid_i) begin
            addr_q  <= dmi_req_addr_i;
            op_q    <= dmi_req_op_i;
            wdata_q <= dmi_req_data_i;
            cnt_q   <= CntW'(ACCESS_CYCLES - 1);
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (ex_reg_we) regs_q[reg_idx] <= wdata_q;
            unlocked_q   <= ex_unlocked;
            lockout_q    <= ex_lockout;
            fail_q       <= ex_fail;
            resp_data_q  <= ex_data;
            resp_resp_q  <= ex_resp;
            resp_valid_q <= 1'b1;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (dmi_resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Ready is forced low for the whole reset pulse, not just from the next edge.
  assign dmi_req_ready_o  = (state_q == StIdle) && !rst_i;
  assign dmi_resp_valid_o = resp_valid_q;
  assign dmi_resp_data_o  = resp_data_q;
  assign dmi_resp_resp_o  = resp_resp_q;
  assign unlocked_o       = unlocked_q;
  assign lockout_o        = lockout_q;

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_o[32*i +: 32] = regs_q[i];
  end

endmodule

// File: tb/tb_dmi_target_resp.sv
module tb_dmi_target_resp;

  localparam logic [31:0] Key = 32'hCAFE_F00D;
  localparam int NRegs = 8;

  logic clk = 1'b0;
  logic rst;
  logic [31:0] jtag_key;
  logic req_valid, req_ready;
  logic [6:0] req_addr;
  logic [1:0] req_op;
  logic [31:0] req_data;
  logic resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [1:0] resp_resp;
  logic unlocked, lockout;
  logic [NRegs*32-1:0] regs;

  // Second instance with a longer access time, used only for the latency check.
  logic v3, rdy3, rv3, rr3, unl3, lo3;
  logic [31:0] rd3;
  logic [1:0] rs3;
  logic [NRegs*32-1:0] regs3;

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  dmi_target_resp u_dut (
    .clk_i(clk), .rst_i(rst), .jtag_key_i(jtag_key),
    .dmi_req_valid_i(req_valid), .dmi_req_ready_o(req_ready),
    .dmi_req_addr_i(req_addr), .dmi_req_op_i(req_op), .dmi_req_data_i(req_data),
    .dmi_resp_valid_o(resp_valid), .dmi_resp_ready_i(resp_ready),
    .dmi_resp_data_o(resp_data), .dmi_resp_resp_o(resp_resp),
    .unlocked_o(unlocked), .lockout_o(lockout), .regs_o(regs)
  );

  dmi_target_resp #(.ACCESS_CYCLES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .jtag_key_i(jtag_key),
    .dmi_req_valid_i(v3), .dmi_req_ready_o(rdy3),
    .dmi_req_addr_i(req_addr), .dmi_req_op_i(req_op), .dmi_req_data_i(req_data),
    .dmi_resp_valid_o(rv3), .dmi_resp_ready_i(rr3),
    .dmi_resp_data_o(rd3), .dmi_resp_resp_o(rs3),
    .unlocked_o(unl3), .lockout_o(lo3), .regs_o(regs3)
  );

  // Reference model: abstract debug-module state.
  logic [31:0] m_regs [NRegs];
  bit m_unl, m_lo;
  int m_fail;

  task automatic model_reset();
    for (int i = 0; i < NRegs; i++) m_regs[i] = '0;
    m_unl = 0; m_lo = 0; m_fail = 0;
  endtask

  task automatic model_exec(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] d,
                            output logic [1:0] r, output logic [31:0] rd);
    int a;
    a = int'(addr);
    r = 2; rd = 0;
    if (op == 0) r = 0;
    else if (op == 3) r = 2;
    else if (a >= 4 && a < 4 + NRegs) begin
      if (m_unl) begin
        r = 0;
        if (op == 1) rd = m_regs[a - 4];
        else m_regs[a - 4] = d;
      end
    end else if (a == 'h40) begin
      if (op == 1) r = 0;
      else if (!m_lo) begin
        if (d == jtag_key) begin m_unl = 1; m_fail = 0; r = 0; end
        else begin
          m_unl = 0;
          m_fail = (m_fail + 1 > 3) ? 3 : m_fail + 1;
          if (m_fail == 3) m_lo = 1;
        end
      end
    end else if (a == 'h41) begin
      r = 0;
      if (op == 1) rd = m_fail * 256 + (m_lo ? 2 : 0) + (m_unl ? 1 : 0);
      else if (d[0]) m_unl = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_in_reset", 32'(req_ready), 32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] d,
                        output logic [1:0] r, output logic [31:0] rd);
    int n;
    r = 'x; rd = 'x;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = d;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (resp_valid) break;
    end
    if (!resp_valid) begin
      check("resp_timeout", 32'd0, 32'd1);
      return;
    end
    r = resp_resp; rd = resp_data;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    logic        exp_unl;
    logic        exp_lo;
  } vec_t;

  vec_t vecs [23];

  initial begin
    logic [1:0] r, er;
    logic [31:0] rd, erd;
    logic [1:0] op;
    logic [6:0] addr;
    logic [31:0] d;
    int sel, n;
    bit stable;

    rst = 1'b1; jtag_key = Key;
    req_valid = 0; req_addr = 0; req_op = 0; req_data = 0; resp_ready = 0;
    v3 = 0; rr3 = 0;
    model_reset();

    vecs[0]  = '{2'd2, 7'h04, 32'h0000_00FF, 2'd2, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{2'd1, 7'h04, 32'h0,         2'd2, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{2'd1, 7'h41, 32'h0,         2'd0, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{2'd2, 7'h40, 32'hCAFE_F00D, 2'd0, 32'h0, 1'b1, 1'b0};
    vecs[4]  = '{2'd2, 7'h05, 32'h0000_1234, 2'd0, 32'h0, 1'b1, 1'b0};
    vecs[5]  = '{2'd1, 7'h05, 32'h0,         2'd0, 32'h1234, 1'b1, 1'b0};
    vecs[6]  = '{2'd1, 7'h40, 32'h0,         2'd0, 32'h0, 1'b1, 1'b0};
    vecs[7]  = '{2'd1, 7'h41, 32'h0,         2'd0, 32'h1, 1'b1, 1'b0};
    vecs[8]  = '{2'd2, 7'h41, 32'h1,         2'd0, 32'h0, 1'b0, 1'b0};
    vecs[9]  = '{2'd1, 7'h05, 32'h0,         2'd2, 32'h0, 1'b0, 1'b0};
    vecs[10] = '{2'd1, 7'h10, 32'h0,         2'd2, 32'h0, 1'b0, 1'b0};
    vecs[11] = '{2'd3, 7'h04, 32'h0,         2'd2, 32'h0, 1'b0, 1'b0};
    vecs[12] = '{2'd0, 7'h04, 32'h0,         2'd0, 32'h0, 1'b0, 1'b0};
    vecs[13] = '{2'd2, 7'h40, 32'hCAFE_F00D, 2'd0, 32'h0, 1'b1, 1'b0};
    vecs[14] = '{2'd1, 7'h0C, 32'h0,         2'd2, 32'h0, 1'b1, 1'b0};
    vecs[15] = '{2'd2, 7'h40, 32'h1111_1111, 2'd2, 32'h0, 1'b0, 1'b0};
    vecs[16] = '{2'd1, 7'h41, 32'h0,         2'd0, 32'h100, 1'b0, 1'b0};
    vecs[17] = '{2'd2, 7'h40, 32'h2222_2222, 2'd2, 32'h0, 1'b0, 1'b0};
    vecs[18] = '{2'd2, 7'h40, 32'h3333_3333, 2'd2, 32'h0, 1'b0, 1'b1};
    vecs[19] = '{2'd1, 7'h41, 32'h0,         2'd0, 32'h302, 1'b0, 1'b1};
    vecs[20] = '{2'd2, 7'h40, 32'hCAFE_F00D, 2'd2, 32'h0, 1'b0, 1'b1};
    vecs[21] = '{2'd2, 7'h40, 32'h4444_4444, 2'd2, 32'h0, 1'b0, 1'b1};
    vecs[22] = '{2'd1, 7'h41, 32'h0,         2'd0, 32'h302, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    check("ready_in_reset", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_unlocked", 32'(unlocked), 32'd0);
    check("reset_lockout", 32'(lockout), 32'd0);
    check("reset_regs_zero", 32'(regs == '0), 32'd1);

    // Directed table.
    for (int i = 0; i < 23; i++) begin
      do_txn(vecs[i].op, vecs[i].addr, vecs[i].data, r, rd);
      check($sformatf("vec%0d_resp", i), 32'(r), 32'(vecs[i].exp_resp));
      check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
      check($sformatf("vec%0d_unlocked", i), 32'(unlocked), 32'(vecs[i].exp_unl));
      check($sformatf("vec%0d_lockout", i), 32'(lockout), 32'(vecs[i].exp_lo));
    end
    check("tbl_reg0", regs[31:0], 32'h0);
    check("tbl_reg1", regs[63:32], 32'h1234);

    // Response back-pressure: held stable, ready low, extra requests ignored.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_addr = 7'h41; req_data = 0;
    @(posedge clk);
    #1 req_op = 2'd2; req_addr = 7'h41; req_data = 32'h1;
    for (n = 0; n < 20; n++) begin @(negedge clk); if (resp_valid) break; end
    check("bp_resp_seen", 32'(resp_valid), 32'd1);
    stable = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!resp_valid || resp_data !== 32'h302 || resp_resp !== 2'd0 || req_ready !== 1'b0)
        stable = 0;
    end
    check("bp_stable", 32'(stable), 32'd1);
    check("bp_data", resp_data, 32'h302);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check("bp_valid_drop", 32'(resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("bp_no_extra_resp", 32'(resp_valid), 32'd0);
    check("bp_idle_ready", 32'(req_ready), 32'd1);

    // Reset while WAIT of a register write.
    do_reset();
    do_txn(2'd2, 7'h40, Key, r, rd);
    check("rw_unlock", 32'(unlocked), 32'd1);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_addr = 7'h04; req_data = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    check("rw_ready_low", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    stable = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) stable = 0;
    end
    check("rw_no_resp", 32'(stable), 32'd1);
    check("rw_regs_zero", 32'(regs == '0), 32'd1);
    check("rw_unlocked", 32'(unlocked), 32'd0);
    check("rw_idle", 32'(req_ready), 32'd1);

    // Randomized traffic against the reference model.
    for (int t = 0; t < 240; t++) begin
      if (t % 30 == 29) do_reset();
      sel = $urandom_range(0, 9);
      if (sel <= 4) addr = 7'(4 + $urandom_range(0, NRegs - 1));
      else if (sel <= 6) addr = 7'h40;
      else if (sel == 7) addr = 7'h41;
      else if (sel == 8) addr = ($urandom_range(0, 1) != 0) ? 7'h03 : 7'h0C;
      else addr = 7'($urandom_range(0, 127));
      sel = $urandom_range(0, 9);
      op = (sel == 0) ? 2'd0 : (sel == 1) ? 2'd3 : (sel <= 5) ? 2'd1 : 2'd2;
      if (addr == 7'h40) d = ($urandom_range(0, 2) != 0) ? Key : $urandom;
      else if (addr == 7'h41) d = 32'($urandom_range(0, 3));
      else d = $urandom;
      model_exec(op, addr, d, er, erd);
      do_txn(op, addr, d, r, rd);
      check($sformatf("rnd%0d_resp op%0d a%h", t, op, addr), 32'(r), 32'(er));
      check($sformatf("rnd%0d_data", t), rd, erd);
      check($sformatf("rnd%0d_unlocked", t), 32'(unlocked), 32'(m_unl));
      check($sformatf("rnd%0d_lockout", t), 32'(lockout), 32'(m_lo));
      for (int i = 0; i < NRegs; i++)
        check($sformatf("rnd%0d_reg%0d", t, i), regs[32*i +: 32], m_regs[i]);
    end

    // Latency with ACCESS_CYCLES=3: response valid three edges after the accepting edge.
    do_reset();
    @(negedge clk);
    v3 = 1'b1; req_op = 2'd1; req_addr = 7'h41; req_data = 0;
    check("lat_ready", 32'(rdy3), 32'd1);
    @(posedge clk);
    #1 v3 = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      n++;
      #1;
      if (rv3) break;
    end
    check("lat_edges", 32'(n), 32'd3);
    check("lat_resp", 32'(rs3), 32'd0);
    check("lat_data", rd3, 32'h0);
    rr3 = 1'b1;
    @(posedge clk);
    #1 rr3 = 1'b0;
    check("lat_drop", 32'(rv3), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
